// File: rtl/pc_fetch_unit.sv
// Program counter and single-outstanding instruction fetch front end with redirect handling.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_PC.
module pc_fetch_unit #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [ADDR_WIDTH-1:0] TRAP_PC     = ADDR_WIDTH'('h100)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_redirect_valid,
  input  logic                   i_redirect_jalr,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_base,
  input  logic [ADDR_WIDTH-1:0]  i_redirect_imm,
  output logic                   o_imem_req,
  output logic [ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                   i_imem_ack,
  input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
  output logic                   o_if_valid,
  input  logic                   i_if_ready,
  output logic [ADDR_WIDTH-1:0]  o_if_pc,
  output logic [ADDR_WIDTH-1:0]  o_if_pc_plus4,
  output logic [INSTR_WIDTH-1:0] o_if_instr,
  output logic                   o_fetch_misalign,
  output logic [ADDR_WIDTH-1:0]  o_bad_addr
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e                 r_state;
  logic                   r_req;
  logic                   r_kill;
  logic [ADDR_WIDTH-1:0]  r_pc;
  logic [ADDR_WIDTH-1:0]  r_saved;
  logic                   r_if_valid;
  logic [ADDR_WIDTH-1:0]  r_if_pc;
  logic [INSTR_WIDTH-1:0] r_if_instr;

  logic [ADDR_WIDTH-1:0]  w_sum;
  logic [ADDR_WIDTH-1:0]  w_target;
  logic [ADDR_WIDTH-1:0]  w_next;

  assign w_sum    = i_redirect_base + i_redirect_imm;
  assign w_target = i_redirect_jalr ? {w_sum[ADDR_WIDTH-1:1], 1'b0} : w_sum;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic                  w_misalign;
  logic                  r_misalign;
  logic [ADDR_WIDTH-1:0] r_bad_addr;

  assign w_misalign       = |w_target[1:0];
  assign w_next           = w_misalign ? TRAP_PC : w_target;
  assign o_fetch_misalign = r_misalign;
  assign o_bad_addr       = r_bad_addr;
`else
  logic w_unused;

  assign w_next           = {w_target[ADDR_WIDTH-1:2], 2'b00};
  assign o_fetch_misalign = 1'b0;
  assign o_bad_addr       = '0;
  assign w_unused         = ^{TRAP_PC, w_target[1:0]};
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_req      <= 1'b0;
      r_kill     <= 1'b0;
      r_pc       <= RESET_PC;
      r_saved    <= '0;
      r_if_valid <= 1'b0;
      r_if_pc    <= '0;
      r_if_instr <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign <= 1'b0;
      r_bad_addr <= '0;
`endif
    end else begin
`ifdef FETCH_MISALIGN_TRAP_EN
      r_misalign <= i_redirect_valid && w_misalign;
      if (i_redirect_valid && w_misalign) begin
        r_bad_addr <= w_target;
      end
`endif
      unique case (r_state)
        StIdle: begin
          r_state <= StReq;
          r_req   <= 1'b1;
          if (i_redirect_valid) begin
            r_pc <= w_next;
          end
        end
        StReq: begin
          // imem_addr is frozen while a request is outstanding, so a redirect is parked
          if (i_redirect_valid) begin
            if (i_imem_ack) begin
              r_pc   <= w_next;
              r_kill <= 1'b0;
            end else begin
              r_kill  <= 1'b1;
              r_saved <= w_next;
            end
          end else if (i_imem_ack) begin
            if (r_kill) begin
              r_pc   <= r_saved;
              r_kill <= 1'b0;
            end else begin
              r_if_instr <= i_imem_rdata;
              r_if_pc    <= r_pc;
              r_if_valid <= 1'b1;
              r_pc       <= r_pc + PC_STEP;
              r_state    <= StHold;
              r_req      <= 1'b0;
            end
          end
        end
        StHold: begin
          if (i_redirect_valid) begin
            r_pc       <= w_next;
            r_if_valid <= 1'b0;
            r_state    <= StReq;
            r_req      <= 1'b1;
          end else if (i_if_ready) begin
            r_if_valid <= 1'b0;
            r_state    <= StReq;
            r_req      <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign o_imem_req    = r_req;
  assign o_imem_addr   = r_pc;
  assign o_if_valid    = r_if_valid;
  assign o_if_pc       = r_if_pc;
  assign o_if_pc_plus4 = r_if_pc + PC_STEP;
  assign o_if_instr    = r_if_instr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: reference model plus directed fetch/redirect scenarios.
// Expectations for misaligned redirects follow FETCH_MISALIGN_TRAP_EN.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_A  = 32'h40;
  localparam logic [31:0] TRAP_A = 32'h180;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT A: 32-bit
  logic        redirect_valid = 1'b0;
  logic        redirect_jalr  = 1'b0;
  logic [31:0] redirect_base  = '0;
  logic [31:0] redirect_imm   = '0;
  logic        imem_ack       = 1'b0;
  logic [31:0] imem_rdata     = '0;
  logic        if_ready       = 1'b1;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_if_valid;
  logic [31:0] o_if_pc;
  logic [31:0] o_if_pc_plus4;
  logic [31:0] o_if_instr;
  logic        o_fetch_misalign;
  logic [31:0] o_bad_addr;

  // DUT B: 16-bit, wrap test
  logic        b_redirect_valid = 1'b0;
  logic        b_redirect_jalr  = 1'b0;
  logic [15:0] b_redirect_base  = '0;
  logic [15:0] b_redirect_imm   = '0;
  logic        b_ack            = 1'b0;
  logic [31:0] b_rdata          = '0;
  logic        b_ready          = 1'b1;
  logic        b_req;
  logic [15:0] b_addr;
  logic        b_valid;
  logic [15:0] b_pc;
  logic [15:0] b_pc4;
  logic [31:0] b_instr;
  logic        b_mis;
  logic [15:0] b_bad;

  pc_fetch_unit #(
    .ADDR_WIDTH (32),
    .INSTR_WIDTH(32),
    .RESET_PC   (RST_A),
    .TRAP_PC    (TRAP_A)
  ) u_dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_redirect_valid(redirect_valid),
    .i_redirect_jalr (redirect_jalr),
    .i_redirect_base (redirect_base),
    .i_redirect_imm  (redirect_imm),
    .o_imem_req      (o_imem_req),
    .o_imem_addr     (o_imem_addr),
    .i_imem_ack      (imem_ack),
    .i_imem_rdata    (imem_rdata),
    .o_if_valid      (o_if_valid),
    .i_if_ready      (if_ready),
    .o_if_pc         (o_if_pc),
    .o_if_pc_plus4   (o_if_pc_plus4),
    .o_if_instr      (o_if_instr),
    .o_fetch_misalign(o_fetch_misalign),
    .o_bad_addr      (o_bad_addr)
  );

  pc_fetch_unit #(
    .ADDR_WIDTH (16),
    .INSTR_WIDTH(32),
    .RESET_PC   (16'hFFFC),
    .TRAP_PC    (16'h0180)
  ) u_dut16 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_redirect_valid(b_redirect_valid),
    .i_redirect_jalr (b_redirect_jalr),
    .i_redirect_base (b_redirect_base),
    .i_redirect_imm  (b_redirect_imm),
    .o_imem_req      (b_req),
    .o_imem_addr     (b_addr),
    .i_imem_ack      (b_ack),
    .i_imem_rdata    (b_rdata),
    .o_if_valid      (b_valid),
    .i_if_ready      (b_ready),
    .o_if_pc         (b_pc),
    .o_if_pc_plus4   (b_pc4),
    .o_if_instr      (b_instr),
    .o_fetch_misalign(b_mis),
    .o_bad_addr      (b_bad)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int lat    = 0;
  int cnt    = 0;
  logic prev_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_0013;
  endfunction

  function automatic logic [31:0] raw_target(input logic j, input logic [31:0] b,
                                             input logic [31:0] i);
    logic [31:0] s;
    s = b + i;
    if (j) s[0] = 1'b0;
    return s;
  endfunction

  function automatic logic misaligned(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t[1:0] != 2'b00;
`else
    return (t[1:0] != 2'b00) && 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: fetch stream expressed as outstanding-request / presented-word bookkeeping
  logic        m_req, m_valid, m_drop, m_mis;
  logic [31:0] m_addr, m_after, m_ipc, m_instr, m_bad;

  always @(posedge clk or posedge rst) begin : model
    logic [31:0] raw;
    logic [31:0] dst;
    logic        bad;
    if (rst) begin
      m_req = 1'b0; m_valid = 1'b0; m_drop = 1'b0; m_mis = 1'b0;
      m_addr = RST_A; m_after = '0; m_ipc = '0; m_instr = '0; m_bad = '0;
    end else begin
      raw   = raw_target(redirect_jalr, redirect_base, redirect_imm);
      bad   = misaligned(raw);
      dst   = bad ? TRAP_A : (raw & ~32'h3);
      m_mis = redirect_valid && bad;
      if (m_mis) m_bad = raw;
      if (m_valid) begin
        if (redirect_valid) begin
          m_valid = 1'b0; m_req = 1'b1; m_addr = dst;
        end else if (if_ready) begin
          m_valid = 1'b0; m_req = 1'b1;
        end
      end else if (!m_req) begin
        m_req = 1'b1;
        if (redirect_valid) m_addr = dst;
      end else if (redirect_valid) begin
        if (imem_ack) begin
          m_addr = dst; m_drop = 1'b0;
        end else begin
          m_drop = 1'b1; m_after = dst;
        end
      end else if (imem_ack) begin
        if (m_drop) begin
          m_drop = 1'b0; m_addr = m_after;
        end else begin
          m_valid = 1'b1; m_req = 1'b0; m_ipc = m_addr;
          m_instr = mem_word(m_addr); m_addr = m_addr + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("imem_req", o_imem_req, m_req);
    check("imem_addr", o_imem_addr, m_addr);
    check("if_valid", o_if_valid, m_valid);
    if (m_valid) begin
      check("if_pc", o_if_pc, m_ipc);
      check("if_instr", o_if_instr, m_instr);
      check("if_pc_plus4", o_if_pc_plus4, m_ipc + 32'd4);
    end
    check("fetch_misalign", o_fetch_misalign, m_mis);
    check("bad_addr", o_bad_addr, m_bad);
  end

  // One clock; then memories respond to the requests now visible
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (prev_req && imem_ack) cnt = 0;
    else if (prev_req) cnt++;
    prev_req   = o_imem_req;
    imem_ack   = o_imem_req && (cnt >= lat);
    imem_rdata = mem_word(o_imem_addr);
    b_ack      = b_req;
    b_rdata    = mem_word({16'h0, b_addr});
  endtask

  task automatic redir(input logic j, input logic [31:0] b, input logic [31:0] i);
    redirect_valid = 1'b1;
    redirect_jalr  = j;
    redirect_base  = b;
    redirect_imm   = i;
  endtask

  task automatic wait_valid(input string name, input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_if_valid && n < limit);
    check({name, "_arrive"}, o_if_valid, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_imem_req", o_imem_req, 1'b0);
    check("rst_imem_addr", o_imem_addr, 32'h40);
    check("rst_if_valid", o_if_valid, 1'b0);
    check("rst_if_pc", o_if_pc, 32'h0);
    check("rst_if_instr", o_if_instr, 32'h0);
    check("rst_misalign", o_fetch_misalign, 1'b0);
    check("rst_bad_addr", o_bad_addr, 32'h0);
    check("rst16_addr", b_addr, 16'hFFFC);
    check("rst16_bad", {b_mis, b_bad}, 17'h0);
    rst = 1'b0;

    // Sequential fetch, zero-wait memory, decode always ready
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("seq_valid", o_if_valid, (k % 2) == 0);
      if ((k % 2) == 0) begin
        check("seq_pc", o_if_pc, 32'h40 + 32'(4 * (k / 2 - 1)));
        check("seq_instr", o_if_instr, mem_word(32'h40 + 32'(4 * (k / 2 - 1))));
      end
      if (k == 2) begin
        check("wrap16_pc", b_pc, 16'hFFFC);
        check("wrap16_pc4", b_pc4, 16'h0000);
        check("wrap16_instr", b_instr, mem_word(32'hFFFC));
      end
      if (k == 4) begin
        check("wrap16_valid", b_valid, 1'b1);
        check("wrap16_next", b_pc, 16'h0000);
      end
    end

    // Branch redirect while holding: held word dropped
    wait_valid("pre_branch", 10);
    redir(1'b0, 32'h100, 32'hFFFF_FFF8);
    tick();
    check("branch_addr", o_imem_addr, 32'hF8);
    check("branch_drop", o_if_valid, 1'b0);

    // JALR during an outstanding slow request
    lat = 3;
    wait_valid("branch_fetch", 10);
    check("branch_pc", o_if_pc, 32'hF8);
    tick();
    check("jalr_in_req", o_imem_req, 1'b1);
    redir(1'b1, 32'h203, 32'h2);
    wait_valid("jalr", 30);
    check("jalr_pc", o_if_pc, 32'h204);

    // Two redirects while one request is outstanding: last wins
    tick();
    redir(1'b0, 32'h300, 32'h0);
    tick();
    redir(1'b0, 32'h400, 32'h0);
    wait_valid("last_wins", 30);
    check("last_wins_pc", o_if_pc, 32'h400);

    // Decode stall with a stray ack while holding
    lat = 0;
    redir(1'b0, 32'h500, 32'h0);
    wait_valid("stall", 10);
    check("stall_pc0", o_if_pc, 32'h500);
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_pc", o_if_pc, 32'h500);
      check("stall_req", o_imem_req, 1'b0);
      if (k == 1) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
      end
    end
    check("stall_instr", o_if_instr, mem_word(32'h500));
    if_ready = 1'b1;
    wait_valid("post_stall", 10);
    check("post_stall_pc", o_if_pc, 32'h504);

    // Misaligned branch target
    redir(1'b0, 32'h100, 32'h2);
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("mis_pulse", o_fetch_misalign, 1'b1);
    check("mis_bad", o_bad_addr, 32'h102);
    check("mis_addr", o_imem_addr, 32'h180);
`else
    check("mis_pulse", o_fetch_misalign, 1'b0);
    check("mis_addr", o_imem_addr, 32'h100);
`endif
    tick();
    check("mis_pulse_end", o_fetch_misalign, 1'b0);

    // Reset in the middle of a slow request; stray ack in the idle cycle
    lat = 3;
    wait_valid("pre_rst", 10);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("mrst_req", o_imem_req, 1'b0);
    check("mrst_addr", o_imem_addr, 32'h40);
    check("mrst_valid", o_if_valid, 1'b0);
    #1;
    rst        = 1'b0;
    cnt        = 0;
    prev_req   = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    wait_valid("post_rst", 20);
    check("post_rst_pc", o_if_pc, 32'h40);
    check("post_rst_instr", o_if_instr, mem_word(32'h40));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
